// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: the M-extension
// ALU control codes, the "no operation" code and the FSM state encoding.
package alu_muldiv_seq_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OPMUL    = 5'd12;
    localparam logic [OP_W-1:0] OPMULH   = 5'd13;
    localparam logic [OP_W-1:0] OPMULHU  = 5'd14;
    localparam logic [OP_W-1:0] OPMULHSU = 5'd15;
    localparam logic [OP_W-1:0] OPDIV    = 5'd16;
    localparam logic [OP_W-1:0] OPDIVU   = 5'd17;
    localparam logic [OP_W-1:0] OPREM    = 5'd18;
    localparam logic [OP_W-1:0] OPREMU   = 5'd19;
    localparam logic [OP_W-1:0] FOPNULL  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } stateT;

endpackage

// File: rtl/alu_muldiv_seq_muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// The accumulator is {hi[WIDTH:0], lo[WIDTH-1:0]}:
//   multiply: hi = partial sum, lo = remaining multiplier bits (add then shift right)
//   divide:   hi = partial remainder, lo = dividend bits shifting out / quotient shifting in
module alu_muldiv_seq_muldiv_step #(
    parameter int WIDTH = 64
) (
    input  logic               isDiv,
    input  logic [2*WIDTH:0]   accIn,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   accOut
);

    logic [WIDTH:0] addend;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;
    logic           ge;

    // Add-shift for multiply, subtract-compare-shift (restoring) for divide
    always_comb begin
        addend   = accIn[0] ? {1'b0, operand} : '0;
        sum      = accIn[2*WIDTH:WIDTH] + addend;
        remShift = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        ge       = (remShift >= {1'b0, operand});
        diff     = remShift - {1'b0, operand};
        if (isDiv) begin
            accOut = {(ge ? diff : remShift), accIn[WIDTH-2:0], ge};
        end else begin
            accOut = {1'b0, sum, accIn[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply/divide unit for the M-extension ALU control codes.
// Operands are reduced to magnitudes at start, iterated one bit per cycle,
// and the sign is restored in the final iteration. Special cases (divide by
// zero, signed overflow, illegal code) complete in one cycle.
// Build option: MULDIV_FAST_MUL_EN -- when defined, all multiplies use a
// combinational product and complete in one cycle like the special cases.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 5
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iStart,
    input  logic [CTRL_W-1:0] iOp,
    input  logic [WIDTH-1:0]  iA,
    input  logic [WIDTH-1:0]  iB,
    output logic              oReady,
    output logic              oDone,
    output logic [WIDTH-1:0]  oResult,
    output logic              oIllegal,
    output logic              oDivZero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = 2 * WIDTH + 1;

    stateT             stateReg, stateNext;
    logic [CNT_W-1:0]  cntReg;
    logic [ACC_W-1:0]  accReg;
    logic [ACC_W-1:0]  stepOut;
    logic [WIDTH-1:0]  operandReg;
    logic              isDivReg, isRemReg, selHighReg, negReg;
    logic [WIDTH-1:0]  resultReg;
    logic              illegalReg, divZeroReg;

    logic opMul, opMulh, opMulhu, opMulhsu, opDiv, opDivu, opRem, opRemu;
    logic opIsMul, opIsDivRem, opLegal;
    logic signA, signB;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] mostNeg;
    logic accept, lastIter;

    logic             special, specIllegal, specDivZero;
    logic [WIDTH-1:0] specResult;

    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quot, rem;
    logic [WIDTH-1:0]   calcResult;

    assign opMul      = (iOp == CTRL_W'(OPMUL));
    assign opMulh     = (iOp == CTRL_W'(OPMULH));
    assign opMulhu    = (iOp == CTRL_W'(OPMULHU));
    assign opMulhsu   = (iOp == CTRL_W'(OPMULHSU));
    assign opDiv      = (iOp == CTRL_W'(OPDIV));
    assign opDivu     = (iOp == CTRL_W'(OPDIVU));
    assign opRem      = (iOp == CTRL_W'(OPREM));
    assign opRemu     = (iOp == CTRL_W'(OPREMU));
    assign opIsMul    = opMul | opMulh | opMulhu | opMulhsu;
    assign opIsDivRem = opDiv | opDivu | opRem | opRemu;
    assign opLegal    = opIsMul | opIsDivRem;

    // Which operands are treated as signed depends on the opcode
    assign signA   = (opMulh | opMulhsu | opDiv | opRem) & iA[WIDTH-1];
    assign signB   = (opMulh | opDiv | opRem) & iB[WIDTH-1];
    assign magA    = signA ? -iA : iA;
    assign magB    = signB ? -iB : iB;
    assign mostNeg = {1'b1, {(WIDTH-1){1'b0}}};

    // A start is taken whenever the unit is not iterating (IDLE or DONE)
    assign accept   = iStart && (stateReg != ST_CALC);
    assign lastIter = (cntReg == CNT_W'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastMag, fastSigned;
    logic [WIDTH-1:0]   fastResult;
    assign fastMag    = (2*WIDTH)'(magA) * (2*WIDTH)'(magB);
    assign fastSigned = (signA ^ signB) ? -fastMag : fastMag;
    assign fastResult = opMul ? fastSigned[WIDTH-1:0] : fastSigned[2*WIDTH-1:WIDTH];
`endif

    // Detect operations that complete in one cycle and their results
    always_comb begin
        special     = 1'b0;
        specResult  = '0;
        specIllegal = 1'b0;
        specDivZero = 1'b0;
        if (!opLegal) begin
            special     = 1'b1;
            specIllegal = 1'b1;
        end else if (opIsDivRem && (iB == '0)) begin
            special     = 1'b1;
            specDivZero = 1'b1;
            specResult  = (opDiv | opDivu) ? '1 : iA;
        end else if ((opDiv | opRem) && (iA == mostNeg) && (&iB)) begin
            special    = 1'b1;
            specResult = opDiv ? mostNeg : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (opIsMul) begin
            special    = 1'b1;
            specResult = fastResult;
        end
`endif
    end

    alu_muldiv_seq_muldiv_step #(
        .WIDTH(WIDTH)
    ) stepInst (
        .isDiv   (isDivReg),
        .accIn   (accReg),
        .operand (operandReg),
        .accOut  (stepOut)
    );

    // Sign fix-up applied to the result of the final iteration
    always_comb begin
        prodFix = negReg ? -stepOut[2*WIDTH-1:0] : stepOut[2*WIDTH-1:0];
        quot    = stepOut[WIDTH-1:0];
        rem     = stepOut[2*WIDTH-1:WIDTH];
        if (isDivReg) begin
            if (isRemReg) begin
                calcResult = negReg ? -rem : rem;
            end else begin
                calcResult = negReg ? -quot : quot;
            end
        end else begin
            calcResult = selHighReg ? prodFix[2*WIDTH-1:WIDTH] : prodFix[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    stateNext = special ? ST_DONE : ST_CALC;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (lastIter) begin
                    stateNext = ST_DONE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        oReady = (stateReg != ST_CALC);
        oDone  = (stateReg == ST_DONE);
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cntReg     <= '0;
            accReg     <= '0;
            operandReg <= '0;
            isDivReg   <= 1'b0;
            isRemReg   <= 1'b0;
            selHighReg <= 1'b0;
            negReg     <= 1'b0;
            resultReg  <= '0;
            illegalReg <= 1'b0;
            divZeroReg <= 1'b0;
        end else if (accept) begin
            cntReg     <= '0;
            isDivReg   <= opIsDivRem;
            isRemReg   <= opRem | opRemu;
            selHighReg <= opMulh | opMulhu | opMulhsu;
            negReg     <= (opRem | opRemu) ? signA : (signA ^ signB);
            // divisor for divide, multiplicand for multiply
            operandReg <= opIsDivRem ? magB : magA;
            // dividend or multiplier starts in the low half
            accReg     <= opIsDivRem ? {{(WIDTH+1){1'b0}}, magA} : {{(WIDTH+1){1'b0}}, magB};
            if (special) begin
                resultReg  <= specResult;
                illegalReg <= specIllegal;
                divZeroReg <= specDivZero;
            end
        end else if (stateReg == ST_CALC) begin
            accReg <= stepOut;
            cntReg <= cntReg + CNT_W'(1);
            if (lastIter) begin
                resultReg  <= calcResult;
                illegalReg <= 1'b0;
                divZeroReg <= 1'b0;
            end
        end
    end

    assign oResult  = resultReg;
    assign oIllegal = illegalReg;
    assign oDivZero = divZeroReg;

endmodule
